hv_reg_access_ctrl: RTL



---
 rtl/hv_reg_access_ctrl_if.sv | 33 +++
 rtl/hv_reg_access_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hv_reg_access_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hv_reg_access_ctrl_if                                        |
// | Description : Arbitrated register-access request/acknowledge bus.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface hv_reg_access_ctrl_if #(
  parameter int REG_AW    = 7,
  parameter int REG_DW    = 8,
  parameter int REG_CRC_W = 8
);
  logic                 wr_req;
  logic                 rd_req;
  logic [REG_AW-1:0]    addr;
  logic [REG_DW-1:0]    wdata;
  logic [REG_CRC_W-1:0] wcrc;
  logic                 wack;
  logic                 rack;
  logic                 err;
  logic [REG_DW-1:0]    data;
  logic [REG_AW-1:0]    ack_addr;

  modport master (
    output wr_req, rd_req, addr, wdata, wcrc,
    input  wack, rack, err, data, ack_addr
  );

  modport slave (
    input  wr_req, rd_req, addr, wdata, wcrc,
    output wack, rack, err, data, ack_addr
  );
endinterface
`default_nettype wire

// File: rtl/hv_reg_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hv_reg_access_ctrl                                           |
// | Description : CRC-checked register access controller for the HV bank.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hv_reg_access_ctrl #(
  parameter int REG_AW    = 7,
  parameter int REG_DW    = 8,
  parameter int REG_CRC_W = 8,
  parameter int REG_NUM   = 96
) (
  input  wire logic                i_clk,
  input  wire logic                i_rst_n,
  hv_reg_access_ctrl_if.slave      rac,
  output logic                     o_reg_wr_en,
  output logic                     o_reg_rd_en,
  output logic [REG_AW-1:0]        o_reg_addr,
  output logic [REG_DW-1:0]        o_reg_wdata,
  input  wire logic [REG_DW-1:0]   i_reg_rdata,
  output logic [7:0]               o_crc_err_cnt
);

  localparam int                    C_MSG_W    = 1 + REG_AW + REG_DW;
  localparam logic [REG_CRC_W-1:0]  C_CRC_POLY = REG_CRC_W'(8'h07);
  localparam logic [REG_AW:0]       C_REG_NUM  = (REG_AW+1)'(REG_NUM);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CHK  = 3'd1,
    S_WR   = 3'd2,
    S_RD   = 3'd3,
    S_RDAT = 3'd4,
    S_ACK  = 3'd5,
    S_GAP  = 3'd6
  } state_t;

  // Bit-serial CRC, MSB first, init 0, no reflection, no final XOR
  function automatic logic [REG_CRC_W-1:0] f_crc(input logic [C_MSG_W-1:0] msg);
    logic [REG_CRC_W-1:0] crc;
    logic                 fb;
    crc = '0;
    for (int i = C_MSG_W - 1; i >= 0; i--) begin
      fb  = crc[REG_CRC_W-1] ^ msg[i];
      crc = {crc[REG_CRC_W-2:0], 1'b0} ^ (fb ? C_CRC_POLY : '0);
    end
    return crc;
  endfunction

  state_t               r_state, w_state_nxt;
  logic [REG_AW-1:0]    r_addr, w_addr_nxt;
  logic [REG_DW-1:0]    r_wdata, w_wdata_nxt;
  logic [REG_CRC_W-1:0] r_wcrc, w_wcrc_nxt;
  logic                 r_wr_en, w_wr_en_nxt;
  logic                 r_rd_en, w_rd_en_nxt;
  logic                 r_wack, w_wack_nxt;
  logic                 r_rack, w_rack_nxt;
  logic                 r_err, w_err_nxt;
  logic [REG_DW-1:0]    r_data, w_data_nxt;
  logic [REG_AW-1:0]    r_ack_addr, w_ack_addr_nxt;
  logic [7:0]           r_cnt, w_cnt_nxt;

  logic                 w_crc_ok;
  logic                 w_addr_ok;
  logic                 w_req_addr_ok;

  assign w_crc_ok      = (f_crc({1'b0, r_addr, r_wdata}) == r_wcrc);
  assign w_addr_ok     = ({1'b0, r_addr} < C_REG_NUM);
  assign w_req_addr_ok = ({1'b0, rac.addr} < C_REG_NUM);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_wcrc_nxt     = r_wcrc;
    w_wr_en_nxt    = 1'b0;
    w_rd_en_nxt    = 1'b0;
    w_wack_nxt     = 1'b0;
    w_rack_nxt     = 1'b0;
    w_err_nxt      = r_err;
    w_data_nxt     = r_data;
    w_ack_addr_nxt = r_ack_addr;
    w_cnt_nxt      = r_cnt;

    case (r_state)
      S_IDLE: begin
        // Write has priority; a simultaneous read is simply dropped
        if (rac.wr_req) begin
          w_addr_nxt  = rac.addr;
          w_wdata_nxt = rac.wdata;
          w_wcrc_nxt  = rac.wcrc;
          w_state_nxt = S_CHK;
        end else if (rac.rd_req) begin
          w_addr_nxt  = rac.addr;
          w_rd_en_nxt = w_req_addr_ok;
          w_state_nxt = S_RD;
        end
      end

      S_CHK: begin
        if (w_crc_ok && w_addr_ok) begin
          w_wr_en_nxt = 1'b1;
          w_state_nxt = S_WR;
        end else begin
          w_wack_nxt     = 1'b1;
          w_err_nxt      = 1'b1;
          w_data_nxt     = '0;
          w_ack_addr_nxt = r_addr;
          if (!w_crc_ok && (r_cnt != 8'hFF)) begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
          w_state_nxt    = S_ACK;
        end
      end

      S_WR: begin
        w_wack_nxt     = 1'b1;
        w_err_nxt      = 1'b0;
        w_data_nxt     = '0;
        w_ack_addr_nxt = r_addr;
        w_state_nxt    = S_ACK;
      end

      S_RD: begin
        if (w_addr_ok) begin
          w_state_nxt = S_RDAT;
        end else begin
          w_rack_nxt     = 1'b1;
          w_err_nxt      = 1'b1;
          w_data_nxt     = '0;
          w_ack_addr_nxt = r_addr;
          w_state_nxt    = S_ACK;
        end
      end

      S_RDAT: begin
        w_rack_nxt     = 1'b1;
        w_err_nxt      = 1'b0;
        w_data_nxt     = i_reg_rdata;
        w_ack_addr_nxt = r_addr;
        w_state_nxt    = S_ACK;
      end

      S_ACK: begin
        w_state_nxt = S_GAP;
      end

      // Held requests are ignored here so they are not accepted twice
      S_GAP: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wcrc     <= '0;
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_wack     <= 1'b0;
      r_rack     <= 1'b0;
      r_err      <= 1'b0;
      r_data     <= '0;
      r_ack_addr <= '0;
      r_cnt      <= 8'h00;
    end else begin
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_wcrc     <= w_wcrc_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_rd_en    <= w_rd_en_nxt;
      r_wack     <= w_wack_nxt;
      r_rack     <= w_rack_nxt;
      r_err      <= w_err_nxt;
      r_data     <= w_data_nxt;
      r_ack_addr <= w_ack_addr_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign rac.wack      = r_wack;
  assign rac.rack      = r_rack;
  assign rac.err       = r_err;
  assign rac.data      = r_data;
  assign rac.ack_addr  = r_ack_addr;
  assign o_reg_wr_en   = r_wr_en;
  assign o_reg_rd_en   = r_rd_en;
  assign o_reg_addr    = r_addr;
  assign o_reg_wdata   = r_wdata;
  assign o_crc_err_cnt = r_cnt;

endmodule
`default_nettype wire
